// File: rtl/axi_burst_issue_pkg.sv
// Shared definitions for the AXI burst issuer: descriptor field layout, AXI constants,
// FSM state encoding and the beat-count type used throughout the block.
package axi_burst_issue_pkg;

   localparam int DESC_W         = 83;
   localparam int DESC_ADDR_LSB  = 0;
   localparam int DESC_ADDR_MSB  = 63;
   localparam int DESC_BYTES_LSB = 64;
   localparam int DESC_BYTES_MSB = 75;
   localparam int DESC_WR_BIT    = 76;
   localparam int DESC_RD_BIT    = 77;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   typedef enum logic [1:0] {IDLE, CALC, ISSUE, GAP} state_t;

   typedef logic [12:0] beats_t;

   function automatic beats_t min_beats(input beats_t a, input beats_t b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/axi_burst_len_calc.sv
// Combinational burst length for the next burst of a segment.
// BURST_BOUNDARY_ALIGN_EN also clips the burst at the next MAX_BURST_LEN*DATA_BYTES boundary.
module axi_burst_len_calc
   import axi_burst_issue_pkg::*;
#(
   parameter int DATA_BYTES    = 8,
   parameter int MAX_BURST_LEN = 16
) (
   input  logic [63:0] addr_i,
   input  logic [12:0] rem_beats_i,
   output logic [12:0] len_o
);

`ifdef BURST_BOUNDARY_ALIGN_EN
   localparam int AW    = $clog2(DATA_BYTES);
   localparam int BOUND = MAX_BURST_LEN * DATA_BYTES;

   logic [12:0] blk_beat;
   logic [12:0] to_bnd;
   logic        unused_addr_hi;

   // Beat index of addr inside its boundary block; an unaligned first beat still counts whole.
   assign blk_beat       = 13'((addr_i[15:0] & 16'(BOUND - 1)) >> AW);
   assign to_bnd         = 13'(MAX_BURST_LEN) - blk_beat;
   assign unused_addr_hi = ^addr_i[63:16];
   assign len_o          = min_beats(rem_beats_i, to_bnd);
`else
   logic unused_addr;

   assign unused_addr = ^addr_i;
   assign len_o       = min_beats(rem_beats_i, 13'(MAX_BURST_LEN));
`endif

endmodule

// File: rtl/axi_burst_issue.sv
// Splits 4KB-safe segment descriptors into AXI4 INCR bursts on AW (write) or AR (read).
// Optional macro BURST_BOUNDARY_ALIGN_EN (see axi_burst_len_calc) aligns bursts to MAX_BURST_LEN*DATA_BYTES.
module axi_burst_issue
   import axi_burst_issue_pkg::*;
#(
   parameter int DATA_BYTES    = 8,
   parameter int MAX_BURST_LEN = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        desc_valid,
   output logic        desc_ready,
   input  logic [82:0] desc_data,
   output logic        awvalid,
   input  logic        awready,
   output logic [63:0] awaddr,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic        arvalid,
   input  logic        arready,
   output logic [63:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        seg_done,
   output logic        desc_err,
   output logic [1:0]  dbg_state_o
);

   localparam int          AW        = $clog2(DATA_BYTES);
   localparam logic [63:0] BEAT_MASK = 64'(DATA_BYTES - 1);

   // Handshake: a burst transfers on a rising edge where xvalid && xready; the
   // address fields stay frozen while xvalid is high and xready is low.

   state_t      state_q, state_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [63:0] addr_q, addr_d;
   logic [11:0] bytes_q, bytes_d;
   beats_t      rem_q, rem_d;
   beats_t      len;
   beats_t      beats;
   beats_t      rem_after;
   logic        hs;
   logic        unused_desc;

   assign unused_desc = ^desc_data[82:78];

   axi_burst_len_calc #(
      .DATA_BYTES    (DATA_BYTES),
      .MAX_BURST_LEN (MAX_BURST_LEN)
   ) u_len_calc (
      .addr_i      (addr_q),
      .rem_beats_i (rem_q),
      .len_o       (len)
   );

   // Start offset within a beat plus byte count, rounded up to whole beats.
   assign beats     = (beats_t'(addr_q[12:0] & BEAT_MASK[12:0]) + beats_t'(bytes_q)
                       + beats_t'(DATA_BYTES - 1)) >> AW;
   assign rem_after = rem_q - len;
   assign hs        = (state_q == ISSUE) && (rd_q ? arready : awready);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         bytes_q <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         bytes_q <= bytes_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      bytes_d    = bytes_q;
      rem_d      = rem_q;
      desc_ready = 1'b0;
      desc_err   = 1'b0;
      seg_done   = 1'b0;
      awvalid    = 1'b0;
      arvalid    = 1'b0;
      case (state_q)
         IDLE: begin
            if (desc_valid && !reset) begin
               desc_ready = 1'b1;
               rd_d       = desc_data[DESC_RD_BIT];
               wr_d       = desc_data[DESC_WR_BIT];
               addr_d     = desc_data[DESC_ADDR_MSB:DESC_ADDR_LSB];
               bytes_d    = desc_data[DESC_BYTES_MSB:DESC_BYTES_LSB];
               state_d    = CALC;
            end
         end
         CALC: begin
            if ((bytes_q == '0) || (rd_q == wr_q)) begin
               desc_err = 1'b1;
               state_d  = IDLE;
            end else begin
               rem_d   = beats;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            awvalid = !rd_q;
            arvalid = rd_q;
            if (hs) begin
               rem_d  = rem_after;
               addr_d = (addr_q & ~BEAT_MASK) + (64'(len) << AW);
               if (rem_after == '0) begin
                  seg_done = 1'b1;
                  state_d  = IDLE;
               end else begin
                  state_d = GAP;
               end
            end
         end
         GAP:     state_d = ISSUE;
         default: state_d = IDLE;
      endcase
   end

   assign awaddr      = awvalid ? addr_q : '0;
   assign awlen       = awvalid ? 8'(len - 1'b1) : '0;
   assign araddr      = arvalid ? addr_q : '0;
   assign arlen       = arvalid ? 8'(len - 1'b1) : '0;
   assign awsize      = 3'(AW);
   assign arsize      = 3'(AW);
   assign awburst     = AXI_BURST_INCR;
   assign arburst     = AXI_BURST_INCR;
   assign dbg_state_o = state_q;

endmodule
